btn_conditioner: RTL and testbench

//  Front end for the stopwatch push-buttons (pause, reset, select, adjust).

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/btn_debounce_ch.sv | 138 +++++++++++++
 rtl/btn_conditioner.sv | 37 +++
 tb/tb_btn_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and timing constants for the stopwatch push-button front end.
package stopwatch_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned CLK_HZ         = 100_000_000;
  localparam int unsigned DB_CYCLES_10MS = CLK_HZ / 100;
  localparam int unsigned REPEAT_500MS   = CLK_HZ / 2;
  localparam int unsigned REPEAT_250MS   = CLK_HZ / 4;

  // Width able to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM, auto-repeat timer.
//
// state        | meaning
// IDLE         | button accepted as released, waiting for s2=1
// PRESS_WAIT   | s2 high, counting stable samples before accepting press
// HELD         | button accepted as pressed, repeat timer running
// RELEASE_WAIT | s2 low while held, counting stable samples before release
module btn_debounce_ch
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DB_CYCLES_10MS,
  parameter int unsigned REPEAT_DLY = REPEAT_500MS,
  parameter int unsigned REPEAT_PER = REPEAT_250MS,
  parameter bit          REPEAT_EN  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
  localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DLY, REPEAT_PER));

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

  logic             s1;
  logic             s2;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [RPT_W-1:0] rpt;
  // Set once the initial repeat delay has elapsed; later pulses use REPEAT_PER.
  logic             rpt_armed;

  // Synchroniser, debounce FSM and repeat timer, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      rpt           <= '0;
      rpt_armed     <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            level       <= 1'b1;
            rpt         <= '0;
            rpt_armed   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
          // The repeat timer advances on every HELD cycle, including the one
          // that drops into RELEASE_WAIT; it is frozen only while in RELEASE_WAIT.
          if (!rpt_armed) begin
            if (rpt == DLY_LAST) begin
              repeat_pulse <= REPEAT_EN;
              rpt          <= '0;
              rpt_armed    <= 1'b1;
            end else begin
              rpt <= rpt + 1'b1;
            end
          end else begin
            if (rpt == PER_LAST) begin
              repeat_pulse <= REPEAT_EN;
              rpt          <= '0;
            end else begin
              rpt <= rpt + 1'b1;
            end
          end
        end

        RELEASE_WAIT: begin
          if (s2) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            level         <= 1'b0;
            rpt           <= '0;
            rpt_armed     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A channel can never report a press and a release in the same cycle.
  a_no_press_and_release : assert property (
    @(posedge clk) disable iff (reset) !(press_pulse && release_pulse)
  );

  // Disabled channels must stay silent on the repeat output.
  a_repeat_masked : assert property (
    @(posedge clk) disable iff (reset) (REPEAT_EN || !repeat_pulse)
  );

endmodule

// File: rtl/btn_conditioner.sv
// Stopwatch push-button front end: one independent debounce channel per pad.
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned     N_BTN       = 4,
  parameter int unsigned     DB_CYCLES   = DB_CYCLES_10MS,
  parameter int unsigned     REPEAT_DLY  = REPEAT_500MS,
  parameter int unsigned     REPEAT_PER  = REPEAT_250MS,
  parameter logic [N_BTN-1:0] REPEAT_MASK = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER),
      .REPEAT_EN  (REPEAT_MASK[i])
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .raw           (btn_raw[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .repeat_pulse  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a run-length reference model.
module tb_btn_conditioner;

  localparam int N     = 4;
  localparam int DB    = 4;
  localparam int DLY   = 8;
  localparam int PER   = 3;
  localparam logic [3:0] MASK = 4'b0010;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  btn_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, edge_n);
    end
  endtask

  // Reference model: a press/release is accepted once the synchronised input
  // has disagreed with the accepted level for DB+1 consecutive samples.
  int         run [N];
  bit         lvl [N];
  bit         ms1 [N];
  bit         ms2 [N];
  int         held_t [N];
  bit         mdl_valid = 1'b0;
  logic [3:0] exp_level, exp_press, exp_release, exp_repeat;

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      mdl_valid = 1'b1;
      for (int c = 0; c < N; c++) begin
        run[c] = 0; lvl[c] = 0; ms1[c] = 0; ms2[c] = 0; held_t[c] = 0;
      end
      exp_press = '0; exp_release = '0; exp_repeat = '0;
    end else begin
      exp_press = '0; exp_release = '0; exp_repeat = '0;
      for (int c = 0; c < N; c++) begin
        if (lvl[c] && run[c] == 0) begin
          held_t[c]++;
          if (MASK[c] && held_t[c] >= DLY && ((held_t[c] - DLY) % PER) == 0)
            exp_repeat[c] = 1'b1;
        end
        if (ms2[c] != lvl[c]) run[c]++; else run[c] = 0;
        if (run[c] == DB + 1) begin
          lvl[c] = !lvl[c];
          run[c] = 0;
          if (lvl[c]) begin exp_press[c] = 1'b1; held_t[c] = 0; end
          else exp_release[c] = 1'b1;
        end
        ms2[c] = ms1[c];
        ms1[c] = btn_raw[c];
      end
    end
    for (int c = 0; c < N; c++) exp_level[c] = lvl[c];
  end

  // Model compare on every cycle.
  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("model_level",   btn_level,   exp_level);
      chk("model_press",   btn_press,   exp_press);
      chk("model_release", btn_release, exp_release);
      chk("model_repeat",  btn_repeat,  exp_repeat);
    end
  end

  // Pulse tallies, sampled just after each edge.
  int press_cnt [N];
  int rel_cnt [N];
  int rep_cnt [N];
  initial for (int c = 0; c < N; c++) begin press_cnt[c] = 0; rel_cnt[c] = 0; rep_cnt[c] = 0; end
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < N; c++) begin
      press_cnt[c] += int'(btn_press[c]);
      rel_cnt[c]   += int'(btn_release[c]);
      rep_cnt[c]   += int'(btn_repeat[c]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 press, 1 release, 2 repeat. Returns the edge that registered it.
  task automatic wait_pulse(input int ch, input int kind, input string nm, output int e);
    bit found;
    found = 1'b0;
    e = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      case (kind)
        0:       found = btn_press[ch];
        1:       found = btn_release[ch];
        default: found = btn_repeat[ch];
      endcase
      if (found) e = edge_n;
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for pulse on channel %0d", nm, ch);
    end
  endtask

  initial begin
    int t0, e, e2, r1, r2, r3, pe, p0, q0, rep0;
    bit [8:0] pat;

    reset = 1'b1;
    btn_raw = '0;
    step(3);
    reset = 1'b0;
    chk("reset_level",   btn_level,   4'h0);
    chk("reset_press",   btn_press,   4'h0);
    chk("reset_release", btn_release, 4'h0);
    step(2);

    // 1: clean press/release on channel 0
    btn_raw[0] = 1'b1;
    t0 = edge_n + 1;
    wait_pulse(0, 0, "t1_press", e);
    chk("t1_press_edge", e - t0 + 1, 7);
    chk("t1_level_hi", btn_level[0], 1'b1);
    while (edge_n - t0 + 1 < 19) @(negedge clk);
    btn_raw[0] = 1'b0;
    wait_pulse(0, 1, "t1_release", e);
    chk("t1_release_edge", e - t0 + 1, 26);
    chk("t1_level_lo", btn_level[0], 1'b0);
    step(10);

    // 2: bounce before settling
    pat = 9'b111110100;   // applied LSB first: 0,0,1,0,1,1,1,1,1 reversed below
    pat = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // bit 0 is applied first; sequence 1,0,1,0,... is corrected by the order below
    pat = 9'b111101011;   // bit order 0..8: 1,1,0,1,0,1,1,1,1
    p0 = press_cnt[0];
    pe = -1;
    t0 = edge_n + 1;
    for (int i = 0; i < 20; i++) begin
      btn_raw[0] = (i < 9) ? pat[i] : 1'b1;
      @(negedge clk);
      if (btn_press[0] && pe < 0) pe = edge_n;
    end
    chk("t2_press_edge", pe - t0 + 1, 12);
    chk("t2_press_count", press_cnt[0] - p0, 1);

    // 3: short release glitch while held
    p0 = press_cnt[0];
    q0 = rel_cnt[0];
    btn_raw[0] = 1'b0;
    step(2);
    btn_raw[0] = 1'b1;
    step(10);
    chk("t3_no_release", rel_cnt[0] - q0, 0);
    chk("t3_no_press", press_cnt[0] - p0, 0);
    chk("t3_level", btn_level[0], 1'b1);
    btn_raw[0] = 1'b0;
    step(12);
    chk("t3_real_release", rel_cnt[0] - q0, 1);

    // 4: auto-repeat on channel 1 only
    rep0 = rep_cnt[0];
    btn_raw[1:0] = 2'b11;
    wait_pulse(1, 0, "t4_press", e);
    wait_pulse(1, 2, "t4_rep1", r1);
    wait_pulse(1, 2, "t4_rep2", r2);
    wait_pulse(1, 2, "t4_rep3", r3);
    chk("t4_first_delay", r1 - e, 8);
    chk("t4_period_a", r2 - r1, 3);
    chk("t4_period_b", r3 - r2, 3);
    chk("t4_masked_ch0", rep_cnt[0] - rep0, 0);
    btn_raw[1:0] = 2'b00;
    step(15);

    // 5: reset in the middle of PRESS_WAIT
    btn_raw[2] = 1'b1;
    step(12);
    chk("t5_ch2_held", btn_level[2], 1'b1);
    btn_raw[0] = 1'b1;
    step(5);
    reset = 1'b1;
    step(1);
    chk("t5_rst_level", btn_level, 4'h0);
    chk("t5_rst_press", btn_press, 4'h0);
    reset = 1'b0;
    t0 = edge_n;
    wait_pulse(0, 0, "t5_press", e);
    chk("t5_press_edge", e - t0, 7);
    chk("t5_press_vec", btn_press, 4'b0101);
    btn_raw = '0;
    step(15);

    // 6: simultaneous presses, independent release
    btn_raw[3:2] = 2'b11;
    wait_pulse(2, 0, "t6_press", e);
    chk("t6_press_vec", btn_press, 4'b1100);
    step(5);
    btn_raw[3] = 1'b0;
    wait_pulse(3, 1, "t6_release", e2);
    chk("t6_release_vec", btn_release, 4'b1000);
    chk("t6_level_vec", btn_level, 4'b0100);
    btn_raw = '0;
    step(15);
    chk("t6_all_idle", btn_level, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
